// File: rtl/sa_out_deskew.sv
// De-skews the systolic-array bottom-row stream and scatters it into the full
// X_R x COLS result matrix; flags completion once the last skewed shift lands.

module sa_out_deskew_lane #(
  parameter int S    = 64,
  parameter int X_R  = 64,
  parameter int C    = 0,
  parameter int DW   = 16,
  parameter int KW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              cap,
  input  logic [KW-1:0]     k,
  input  logic [DW-1:0]     din,
  output logic [X_R*DW-1:0] col
);
  // Row r of this column arrives on shift k = r + C + S-1.
  for (genvar r = 0; r < X_R; r++) begin : g_row
    localparam int KHIT = r + C + S - 1;
    logic [DW-1:0] elem_q;
    always_ff @(posedge clk) begin
      if (rst || clr)
        elem_q <= '0;
      else if (cap && (k == KW'(KHIT)))
        elem_q <= din;
    end
    assign col[r*DW +: DW] = elem_q;
  end
endmodule

module sa_out_deskew #(
  parameter int S    = 64,
  parameter int X_R  = 64,
  parameter int COLS = 64,
  parameter int DW   = 16
) (
  input  logic                   I_CLK,
  input  logic                   I_RST,
  input  logic                   I_START_FLAG,
  input  logic                   I_SHIFT,
  input  logic [COLS*DW-1:0]     I_SA_OUT,
  output logic                   O_BUSY,
  output logic                   O_OUT_VLD,
  output logic                   O_DONE,
  output logic [X_R*COLS*DW-1:0] O_OUT
);
  localparam int NSHIFT = X_R + COLS + S - 2;
  localparam int KW     = $clog2(NSHIFT + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          busy_q, vld_q, vld_d, done_q, done_d;
  logic          clr, cap;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    cap     = 1'b0;
    if (I_START_FLAG) begin
      // Start wins over any coincident shift and aborts an in-flight matrix.
      state_d = COLLECT;
      k_d     = '0;
      vld_d   = 1'b0;
      clr     = 1'b1;
    end else if (state_q == COLLECT && I_SHIFT) begin
      cap = 1'b1;
      if (k_q == KW'(NSHIFT - 1)) begin
        state_d = DONE;
        vld_d   = 1'b1;
        done_d  = 1'b1;
      end else begin
        k_d = k_q + 1'b1;
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q <= IDLE;
      k_q     <= '0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      busy_q  <= (state_d == COLLECT);
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  assign O_BUSY    = busy_q;
  assign O_OUT_VLD = vld_q;
  assign O_DONE    = done_q;

  for (genvar c = 0; c < COLS; c++) begin : g_lane
    logic [X_R*DW-1:0] col;
    sa_out_deskew_lane #(
      .S(S), .X_R(X_R), .C(c), .DW(DW), .KW(KW)
    ) u_lane (
      .clk (I_CLK),
      .rst (I_RST),
      .clr (clr),
      .cap (cap),
      .k   (k_q),
      .din (I_SA_OUT[c*DW +: DW]),
      .col (col)
    );
    for (genvar r = 0; r < X_R; r++) begin : g_map
      assign O_OUT[(r*COLS+c)*DW +: DW] = col[r*DW +: DW];
    end
  end
endmodule

// File: tb/tb_sa_out_deskew.sv
// Directed bench for sa_out_deskew with S=2, X_R=3, COLS=2 (five shifts per matrix).

module tb_sa_out_deskew;
  localparam int S = 2, X_R = 3, COLS = 2, DW = 16;
  localparam logic [95:0] EXP_PAT = 96'h2004_1003_2003_1002_2002_1001;
  localparam logic [95:0] EXP_NEG = 96'h8001_8001_8001_8001_8001_8001;

  logic                   clk = 1'b0;
  logic                   rst, st, sh;
  logic [COLS*DW-1:0]     sa;
  logic                   busy, vld, done;
  logic [X_R*COLS*DW-1:0] out;

  int errs = 0, checks = 0;

  sa_out_deskew #(.S(S), .X_R(X_R), .COLS(COLS), .DW(DW)) dut (
    .I_CLK(clk), .I_RST(rst), .I_START_FLAG(st), .I_SHIFT(sh),
    .I_SA_OUT(sa), .O_BUSY(busy), .O_OUT_VLD(vld), .O_DONE(done), .O_OUT(out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int k);
    logic [15:0] a, b;
    a = 16'h1000 + 16'(k);
    b = 16'h2000 + 16'(k);
    return {b, a};
  endfunction

  // Inputs change on negedge; outputs are sampled on negedge before re-driving.
  task automatic start();
    st = 1'b1; @(negedge clk); st = 1'b0;
  endtask

  task automatic shift(input logic [31:0] d, input int gap);
    sa = d; sh = 1'b1; @(negedge clk); sh = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic run_pattern(input string tag, input int gap);
    for (int k = 0; k < 4; k++) shift(pat(k), gap);
    chk({tag, "_done_early"}, 128'(done), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(1));
    shift(pat(4), 0);
    chk({tag, "_done"}, 128'(done), 128'(1));
    chk({tag, "_vld"}, 128'(vld), 128'(1));
    chk({tag, "_busy_off"}, 128'(busy), 128'(0));
    chk({tag, "_out"}, 128'(out), 128'(EXP_PAT));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 128'(done), 128'(0));
    chk({tag, "_vld_hold"}, 128'(vld), 128'(1));
  endtask

  initial begin
    rst = 1'b1; st = 1'b0; sh = 1'b0; sa = '0;
    // 1: reset with shift toggling
    for (int i = 0; i < 4; i++) begin
      sh = ~sh; sa = 32'hDEAD_BEEF; @(negedge clk);
    end
    chk("t1_busy", 128'(busy), 128'(0));
    chk("t1_vld",  128'(vld),  128'(0));
    chk("t1_done", 128'(done), 128'(0));
    chk("t1_out",  128'(out),  128'(0));
    rst = 1'b0;
    for (int i = 0; i < 3; i++) shift(32'hDEAD_BEEF, 0);
    chk("t1_out_nostart", 128'(out), 128'(0));
    chk("t1_busy_nostart", 128'(busy), 128'(0));

    // 2: back-to-back shifts
    start();
    chk("t2_busy_start", 128'(busy), 128'(1));
    run_pattern("t2", 0);

    // 3: gapped shifts
    start();
    chk("t3_out_clr", 128'(out), 128'(0));
    chk("t3_vld_clr", 128'(vld), 128'(0));
    run_pattern("t3", 3);

    // 4: shifts after DONE ignored
    shift(32'hFFFF_FFFF, 0);
    chk("t4_done_a", 128'(done), 128'(0));
    shift(32'hFFFF_FFFF, 0);
    chk("t4_done_b", 128'(done), 128'(0));
    chk("t4_out", 128'(out), 128'(EXP_PAT));
    chk("t4_vld", 128'(vld), 128'(1));

    // 5: abort after 3 shifts via start colliding with a shift
    start();
    for (int k = 0; k < 3; k++) shift(32'hAAAA_AAAA, 0);
    sa = 32'h5555_5555; st = 1'b1; sh = 1'b1; @(negedge clk);
    st = 1'b0; sh = 1'b0;
    chk("t5_out_clr", 128'(out), 128'(0));
    chk("t5_busy", 128'(busy), 128'(1));
    run_pattern("t5", 0);

    // 6: reset mid-collect
    start();
    shift(pat(0), 0); shift(pat(1), 0); shift(pat(2), 0);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("t6_busy", 128'(busy), 128'(0));
    chk("t6_vld",  128'(vld),  128'(0));
    chk("t6_done", 128'(done), 128'(0));
    chk("t6_out",  128'(out),  128'(0));
    shift(pat(3), 0);
    chk("t6_idle_shift", 128'(out), 128'(0));
    start();
    run_pattern("t6", 1);

    // 7: negative data bit-exact
    start();
    for (int k = 0; k < 5; k++) shift(32'h8001_8001, 0);
    chk("t7_done", 128'(done), 128'(1));
    chk("t7_out", 128'(out), 128'(EXP_NEG));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
